// File: rtl/router_ctrl_fsm_if.sv
// router_ctrl_fsm_if: handshake and status bundle between the router
// controller, the input register block and the FIFO bank.
// master = the surrounding datapath, slave = the controller FSM.
interface router_ctrl_fsm_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_rst;

  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              full_state;
  logic              laf_state;
  logic              rst_int_reg;
  logic              write_enb_reg;
  logic              busy;
  logic [NUM_CH-1:0] fifo_we;
  logic [ADDR_W-1:0] addr_q;
  logic              len_err;
  logic              wait_timeout;

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid,
           fifo_full, fifo_empty, soft_rst,
    input  detect_addr, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy, fifo_we, addr_q,
           len_err, wait_timeout
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid,
           fifo_full, fifo_empty, soft_rst,
    output detect_addr, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy, fifo_we, addr_q,
           len_err, wait_timeout
  );
endinterface

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm: decodes the packet header, picks one of NUM_CH output
// FIFOs and sequences header / payload / parity loads, handling FIFO-full
// stalls, per-channel soft reset, invalid addresses and length checking.
// Optional feature: define ROUTER_WAIT_TIMEOUT_EN to give up on a busy
// destination after TIMEOUT_CYC cycles in WAIT_TILL_EMPTY.
module router_ctrl_fsm #(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  router_ctrl_fsm_if.slave bus
);

  localparam int LEN_W = DATA_W - ADDR_W;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  // Reject parameter sets the header format cannot express.
  if (NUM_CH < 2 || NUM_CH > 8 || (1 << ADDR_W) < NUM_CH ||
      ADDR_W >= DATA_W || TIMEOUT_CYC < 2) begin : gBadParams
    $error("router_ctrl_fsm: illegal parameter combination");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_q;
  logic [LEN_W-1:0]  expLen_q;
  logic [LEN_W-1:0]  payCnt_q;
  logic              lenErr_q;

  logic [ADDR_W-1:0] hdrAddr;
  logic [NUM_CH-1:0] hdrOneHot;
  logic [NUM_CH-1:0] selOneHot;
  logic              hdrValid;
  logic              hdrEmpty;
  logic              selFull;
  logic              selEmpty;
  logic              selSoftRst;
  logic              timeoutHit;

  assign hdrAddr = bus.data_in[ADDR_W-1:0];

  // One-hot channel selects; an out-of-range address gives an all-zero
  // vector, so it can never touch or be affected by a real channel.
  always_comb begin
    hdrOneHot = '0;
    selOneHot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hdrOneHot[i] = (int'(hdrAddr) == i);
      selOneHot[i] = (int'(dest_q) == i);
    end
  end

  assign hdrValid   = |hdrOneHot;
  assign hdrEmpty   = |(hdrOneHot & bus.fifo_empty);
  assign selFull    = |(selOneHot & bus.fifo_full);
  assign selEmpty   = |(selOneHot & bus.fifo_empty);
  assign selSoftRst = |(selOneHot & bus.soft_rst);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] waitCnt_q;

  assign timeoutHit = (state_q == WAIT_TILL_EMPTY) && !selEmpty &&
                      (waitCnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state selection; soft reset of the selected channel overrides
  // everything except the hard reset, timeout sits just below it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          if (!hdrValid)     state_d = DROP_PACKET;
          else if (hdrEmpty) state_d = LOAD_FIRST_DATA;
          else               state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (selFull)             state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!selFull) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = selFull ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (selEmpty)        state_d = LOAD_FIRST_DATA;
        else if (timeoutHit) state_d = DROP_PACKET;
      end
      DROP_PACKET: begin
        if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
      end
      default:            state_d = DECODE_ADDRESS;
    endcase
    if (state_q != DECODE_ADDRESS && selSoftRst) state_d = DECODE_ADDRESS;
  end

  // All controller state: FSM, latched header fields, payload counter,
  // length-error flag and (optionally) the wait timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DECODE_ADDRESS;
      dest_q   <= '0;
      expLen_q <= '0;
      payCnt_q <= '0;
      lenErr_q <= 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
      waitCnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;

      if (state_q == DECODE_ADDRESS && bus.pkt_valid) begin
        dest_q   <= hdrAddr;
        expLen_q <= bus.data_in[DATA_W-1:ADDR_W];
      end

      if (state_q != DECODE_ADDRESS && selSoftRst)
        payCnt_q <= '0;
      else if (state_q == LOAD_FIRST_DATA)
        payCnt_q <= '0;
      else if (state_q == LOAD_DATA && bus.pkt_valid && !selFull &&
               payCnt_q != '1)
        payCnt_q <= payCnt_q + 1'b1;

      if (state_q == LOAD_FIRST_DATA)
        lenErr_q <= 1'b0;
      else if (state_q == CHECK_PARITY_ERROR)
        lenErr_q <= (payCnt_q != expLen_q);

`ifdef ROUTER_WAIT_TIMEOUT_EN
      waitCnt_q <= (state_q == WAIT_TILL_EMPTY) ? waitCnt_q + 1'b1 : '0;
`endif
    end
  end

  assign bus.detect_addr   = (state_q == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_q == LOAD_DATA);
  assign bus.full_state    = (state_q == FIFO_FULL_STATE);
  assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
  assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_q == LOAD_DATA) ||
                             (state_q == LOAD_AFTER_FULL) ||
                             (state_q == LOAD_PARITY);
  assign bus.busy          = (state_q == LOAD_FIRST_DATA) ||
                             (state_q == FIFO_FULL_STATE) ||
                             (state_q == LOAD_AFTER_FULL) ||
                             (state_q == LOAD_PARITY) ||
                             (state_q == CHECK_PARITY_ERROR) ||
                             (state_q == WAIT_TILL_EMPTY);
  assign bus.fifo_we       = selOneHot &
                             {NUM_CH{bus.write_enb_reg | bus.lfd_state}};
  assign bus.addr_q        = dest_q;
  assign bus.len_err       = lenErr_q;
  assign bus.wait_timeout  = timeoutHit & ~selSoftRst;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// tb_router_ctrl_fsm: directed cycle-by-cycle checks of router_ctrl_fsm
// with NUM_CH=3, ADDR_W=2, DATA_W=8, TIMEOUT_CYC=4.
module tb_router_ctrl_fsm;
  localparam int NUM_CH      = 3;
  localparam int ADDR_W      = 2;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 4;

  // Expected state decodes packed as
  // {detect_addr, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] V_DA   = 8'b1000_0000;
  localparam logic [7:0] V_LFD  = 8'b0100_0001;
  localparam logic [7:0] V_LD   = 8'b0010_0010;
  localparam logic [7:0] V_FFS  = 8'b0001_0001;
  localparam logic [7:0] V_LAF  = 8'b0000_1011;
  localparam logic [7:0] V_LP   = 8'b0000_0011;
  localparam logic [7:0] V_CPE  = 8'b0000_0101;
  localparam logic [7:0] V_WTE  = 8'b0000_0001;
  localparam logic [7:0] V_DROP = 8'b0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  router_ctrl_fsm_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  router_ctrl_fsm #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [7:0] d,
                               input logic [2:0] full, input logic [2:0] empty,
                               input logic [2:0] srst, input logic pdone,
                               input logic lpv);
    bus.pkt_valid     = pv;
    bus.data_in       = d;
    bus.fifo_full     = full;
    bus.fifo_empty    = empty;
    bus.soft_rst      = srst;
    bus.parity_done   = pdone;
    bus.low_pkt_valid = lpv;
  endtask

  task automatic expectState(input string tag, input logic [7:0] v,
                             input logic [2:0] we);
    logic [7:0] obs;
    obs = {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.full_state,
           bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    checkOutput({tag, ".state"}, 32'(obs), 32'(v));
    checkOutput({tag, ".we"}, 32'(bus.fifo_we), 32'(we));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Header addr 1 into empty FIFOs; nPay counted payload cycles, then the
  // parity byte arrives with pkt_valid low (still written from LOAD_DATA).
  task automatic runPacket(input string tag, input logic [7:0] hdr,
                           input int nPay, input logic expErr);
    applyStimulus(1'b1, hdr, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState({tag, ".da"}, V_DA, 3'b000);
    tick();
    applyStimulus(1'b1, 8'hA0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState({tag, ".lfd"}, V_LFD, 3'b010);
    checkOutput({tag, ".addr"}, 32'(bus.addr_q), 32'd1);
    tick();
    for (int i = 0; i < nPay; i++) begin
      applyStimulus(1'b1, 8'(8'hA1 + i), 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
      expectState({tag, ".ld"}, V_LD, 3'b010);
      tick();
    end
    applyStimulus(1'b0, 8'h5A, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState({tag, ".ldpar"}, V_LD, 3'b010);
    tick();
    expectState({tag, ".lp"}, V_LP, 3'b010);
    tick();
    expectState({tag, ".cpe"}, V_CPE, 3'b000);
    tick();
    expectState({tag, ".end"}, V_DA, 3'b000);
    checkOutput({tag, ".lenerr"}, 32'(bus.len_err), 32'(expErr));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    expectState("reset", V_DA, 3'b000);
    checkOutput("reset.addr", 32'(bus.addr_q), 32'd0);
    checkOutput("reset.lenerr", 32'(bus.len_err), 32'd0);
    checkOutput("reset.tmo", 32'(bus.wait_timeout), 32'd0);
    rst = 1'b0;

    // Length matches header (len 3), then an over-long packet (5 bytes).
    runPacket("good", 8'h0D, 3, 1'b0);
    tick();
    runPacket("long", 8'h0D, 5, 1'b1);
    tick();

    // len_err survives into the next header and clears after LOAD_FIRST_DATA;
    // this packet also stalls on fifo_full[1].
    applyStimulus(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    checkOutput("stall.errHeld", 32'(bus.len_err), 32'd1);
    tick();
    applyStimulus(1'b1, 8'hA0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("stall.lfd", V_LFD, 3'b010);
    tick();
    applyStimulus(1'b1, 8'hA1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    checkOutput("stall.errClr", 32'(bus.len_err), 32'd0);
    tick();
    applyStimulus(1'b1, 8'hA2, 3'b010, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("stall.ldFull", V_LD, 3'b010);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hA2, 3'b010, 3'b111, 3'b000, 1'b0, 1'b0);
      expectState("stall.ffs", V_FFS, 3'b000);
      tick();
    end
    applyStimulus(1'b1, 8'hA2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("stall.ffsLast", V_FFS, 3'b000);
    tick();
    applyStimulus(1'b1, 8'hA2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("stall.laf", V_LAF, 3'b010);
    tick();
    applyStimulus(1'b1, 8'hA3, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("stall.ld2", V_LD, 3'b010);
    tick();
    applyStimulus(1'b1, 8'hA4, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    // full rising together with pkt_valid falling: full wins
    applyStimulus(1'b0, 8'h5A, 3'b010, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("stall.ld3", V_LD, 3'b010);
    tick();
    applyStimulus(1'b0, 8'h5A, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1);
    expectState("stall.fullWins", V_FFS, 3'b000);
    tick();
    applyStimulus(1'b0, 8'h5A, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1);
    expectState("stall.laf2", V_LAF, 3'b010);
    tick();
    expectState("stall.lp", V_LP, 3'b010);
    tick();
    expectState("stall.cpe", V_CPE, 3'b000);
    tick();
    expectState("stall.end", V_DA, 3'b000);
    checkOutput("stall.lenerr", 32'(bus.len_err), 32'd0);

    // Invalid address 3 is dropped without busy or writes.
    applyStimulus(1'b1, 8'h0B, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hB0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
      expectState("drop.hold", V_DROP, 3'b000);
      tick();
    end
    checkOutput("drop.addr", 32'(bus.addr_q), 32'd3);
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("drop.last", V_DROP, 3'b000);
    tick();
    expectState("drop.end", V_DA, 3'b000);

    // Soft reset: channel 0 ignored, selected channel 1 returns to DA.
    applyStimulus(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA1, 3'b000, 3'b111, 3'b001, 1'b0, 1'b0);
    expectState("srst.ld", V_LD, 3'b010);
    tick();
    applyStimulus(1'b1, 8'hA2, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0);
    expectState("srst.other", V_LD, 3'b010);
    tick();
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("srst.da", V_DA, 3'b000);
    checkOutput("srst.addr", 32'(bus.addr_q), 32'd1);
    tick();

    // Destination 2 not empty: wait (and time out when enabled).
    applyStimulus(1'b1, 8'h0E, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0);
    tick();
`ifdef ROUTER_WAIT_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 8'hE1, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0);
      expectState("wte.wait", V_WTE, 3'b000);
      checkOutput("wte.tmo", 32'(bus.wait_timeout), (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0);
    expectState("wte.drop", V_DROP, 3'b000);
    checkOutput("wte.tmoEnd", 32'(bus.wait_timeout), 32'd0);
    tick();
    expectState("wte.end", V_DA, 3'b000);
`else
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'hE1, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0);
      expectState("wte.wait", V_WTE, 3'b000);
      checkOutput("wte.tmo", 32'(bus.wait_timeout), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 8'hE1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("wte.lfd", V_LFD, 3'b100);
    tick();
    expectState("wte.ld", V_LD, 3'b100);
    tick();
    expectState("wte.lp", V_LP, 3'b100);
    tick();
    tick();
    expectState("wte.end", V_DA, 3'b000);
    checkOutput("wte.lenerr", 32'(bus.len_err), 32'd1);
`endif
    tick();

    // Hard reset mid-payload wins over everything.
    applyStimulus(1'b1, 8'h05, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA1, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    expectState("rst2", V_DA, 3'b000);
    checkOutput("rst2.addr", 32'(bus.addr_q), 32'd0);
    checkOutput("rst2.lenerr", 32'(bus.len_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
